// File: rtl/multi_al_controller.sv
// Multi-slot alarm clock controller: keypad FSM (IDLE/ENTRY/SHOW), per-slot alarm
// registers with arm/trigger logic, and a ring timer silenced by any key.

module multi_al_slot #(
   parameter int TW = 16
) (
   input  logic          clk256,
   input  logic          reset,
   input  logic          wr_i,
   input  logic          tog_i,
   input  logic          one_second_i,
   input  logic [TW-1:0] wdata_i,
   input  logic [TW-1:0] cur_time_i,
   output logic [TW-1:0] time_o,
   output logic          en_o,
   output logic          hit_o
);
   logic [TW-1:0] time_q;
   logic          en_q, armed_q, match;

   assign match  = (cur_time_i == time_q);
   assign hit_o  = one_second_i & en_q & armed_q & match;
   assign time_o = time_q;
   assign en_o   = en_q;

   always_ff @(posedge clk256 or negedge reset) begin
      if (!reset) begin
         time_q  <= '0;
         en_q    <= 1'b0;
         armed_q <= 1'b1;
      end else begin
         if (wr_i) begin
            time_q <= wdata_i;
            en_q   <= 1'b1;
         end else if (tog_i) begin
            en_q <= ~en_q;
         end
         // a slot fires once per match; it re-arms only after time moves away
         if (hit_o)       armed_q <= 1'b0;
         else if (!match) armed_q <= 1'b1;
      end
   end
endmodule

module multi_al_controller #(
   parameter  int NUM_ALARMS = 4,
   parameter  int DIGITS     = 4,
   parameter  int TIMEOUT_S  = 10,
   parameter  int RING_S     = 60,
   localparam int SW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
   localparam int TW         = 4 * DIGITS
) (
   input  logic                  clk256,
   input  logic                  reset,
   input  logic                  one_second,
   input  logic [7:0]            key,
   input  logic                  key_valid,
   input  logic [TW-1:0]         key_buffer,
   input  logic [TW-1:0]         cur_time,
   output logic                  shift,
   output logic                  load_new_time,
   output logic                  load_alarm,
   output logic                  show_alarm,
   output logic [SW-1:0]         slot,
   output logic [TW-1:0]         alarm_time,
   output logic [NUM_ALARMS-1:0] alarm_en,
   output logic                  alarm_ring,
   output logic [SW-1:0]         ring_slot
);
   localparam logic [7:0] K_ALARM  = 8'h2A;
   localparam logic [7:0] K_TIME   = 8'h2D;
   localparam logic [7:0] K_NEXT   = 8'h2B;
   localparam logic [7:0] K_TOGGLE = 8'h2F;
   localparam logic [7:0] K_SHOW   = 8'h2E;
   localparam int TCW = $clog2(TIMEOUT_S + 1);
   localparam int RCW = $clog2(RING_S + 1);

   typedef enum logic [1:0] {IDLE, ENTRY, SHOW} state_t;

   state_t                       state_q, state_d;
   logic [SW-1:0]                slot_q, slot_d, slot_nxt, rslot_q, rslot_d;
   logic [TW-1:0]                at_q, at_d;
   logic [TCW-1:0]               tmo_q, tmo_d;
   logic [RCW-1:0]               rcnt_q, rcnt_d;
   logic                         shift_q, shift_d, lnt_q, lnt_d, la_q, la_d;
   logic                         ring_q, ring_d, wr, tog, is_digit;
   logic [NUM_ALARMS-1:0]        wr_vec, tog_vec, en_vec, hit;
   logic [NUM_ALARMS-1:0][TW-1:0] slot_time;

   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
      multi_al_slot #(.TW(TW)) u_slot (
         .clk256       (clk256),
         .reset        (reset),
         .wr_i         (wr_vec[g]),
         .tog_i        (tog_vec[g]),
         .one_second_i (one_second),
         .wdata_i      (key_buffer),
         .cur_time_i   (cur_time),
         .time_o       (slot_time[g]),
         .en_o         (en_vec[g]),
         .hit_o        (hit[g])
      );
   end

   assign is_digit = (key <= 8'h09);
   assign slot_nxt = (slot_q == SW'(NUM_ALARMS - 1)) ? '0 : slot_q + 1'b1;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      shift_d = 1'b0;
      lnt_d   = 1'b0;
      la_d    = 1'b0;
      wr      = 1'b0;
      tog     = 1'b0;
      tmo_d   = tmo_q;
      ring_d  = ring_q;
      rslot_d = rslot_q;
      rcnt_d  = rcnt_q;

      if (key_valid) begin
         tmo_d = '0;
      end else if (one_second && state_q != IDLE) begin
         if (tmo_q == TCW'(TIMEOUT_S - 1)) begin
            tmo_d   = '0;
            state_d = IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      // a key arriving while ringing only silences the alarm
      if (key_valid && !ring_q) begin
         case (state_q)
            IDLE: begin
               if (is_digit) begin
                  shift_d = 1'b1;
                  state_d = ENTRY;
               end else if (key == K_NEXT)   slot_d  = slot_nxt;
               else if (key == K_TOGGLE)     tog     = 1'b1;
               else if (key == K_SHOW)       state_d = SHOW;
            end
            ENTRY: begin
               if (is_digit) begin
                  shift_d = 1'b1;
               end else if (key == K_ALARM) begin
                  la_d    = 1'b1;
                  wr      = 1'b1;
                  state_d = IDLE;
               end else if (key == K_TIME) begin
                  lnt_d   = 1'b1;
                  state_d = IDLE;
               end
            end
            SHOW: begin
               if (key == K_NEXT)      slot_d  = slot_nxt;
               else if (key == K_SHOW) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      if (ring_q) begin
         if (key_valid) begin
            ring_d = 1'b0;
            rcnt_d = '0;
         end else if (one_second) begin
            if (rcnt_q == RCW'(RING_S - 1)) begin
               ring_d = 1'b0;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
      end else if (|hit) begin
         ring_d = 1'b1;
         rcnt_d = '0;
         for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (hit[i]) rslot_d = SW'(i);
      end

      // registered alarm_time tracks the slot/value being written this cycle
      at_d = slot_time[0];
      for (int i = 0; i < NUM_ALARMS; i++)
         if (slot_d == SW'(i)) at_d = slot_time[i];
      if (wr) at_d = key_buffer;
   end

   always_comb begin
      wr_vec  = '0;
      tog_vec = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         wr_vec[i]  = wr  && (slot_q == SW'(i));
         tog_vec[i] = tog && (slot_q == SW'(i));
      end
   end

   always_ff @(posedge clk256 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         slot_q  <= '0;
         rslot_q <= '0;
         at_q    <= '0;
         tmo_q   <= '0;
         rcnt_q  <= '0;
         shift_q <= 1'b0;
         lnt_q   <= 1'b0;
         la_q    <= 1'b0;
         ring_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         rslot_q <= rslot_d;
         at_q    <= at_d;
         tmo_q   <= tmo_d;
         rcnt_q  <= rcnt_d;
         shift_q <= shift_d;
         lnt_q   <= lnt_d;
         la_q    <= la_d;
         ring_q  <= ring_d;
      end
   end

   assign shift         = shift_q;
   assign load_new_time = lnt_q;
   assign load_alarm    = la_q;
   assign show_alarm    = (state_q == SHOW);
   assign slot          = slot_q;
   assign alarm_time    = at_q;
   assign alarm_en      = en_vec;
   assign alarm_ring    = ring_q;
   assign ring_slot     = rslot_q;
endmodule

// File: doc/multi_al_controller.md
MULTI_AL_CONTROLLER -- requirements
Module: multi_al_controller

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4, number of alarm slots (legal 1..8).
REQ-002 SHALL have parameter DIGITS, default 4, BCD digits per time value (hhmm).
REQ-003 SHALL have parameter TIMEOUT_S, default 10, idle seconds before entry/show mode is abandoned.
REQ-004 SHALL have parameter RING_S, default 60, seconds an unanswered alarm rings.
REQ-005 SHALL have local SW = max(1, clog2(NUM_ALARMS)); TW = 4*DIGITS.
REQ-006 clk256  in  1  sole clock, 256 Hz, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-008 one_second  in  1  one-clk256-cycle pulse per second.
REQ-009 key  in  8  decoded key code from kbd_if.
REQ-010 key_valid  in  1  one-cycle strobe, key is valid.
REQ-011 key_buffer  in  TW  digits entered so far (kbd_if shift register).
REQ-012 cur_time  in  TW  current BCD time.
REQ-013 shift  out  1  one-cycle pulse: push digit into key_buffer.
REQ-014 load_new_time  out  1  one-cycle pulse: load key_buffer into time counter.
REQ-015 load_alarm  out  1  one-cycle pulse: slot written.
REQ-016 show_alarm  out  1  high while in SHOW.
REQ-017 slot  out  SW  currently selected slot.
REQ-018 alarm_time  out  TW  stored time of selected slot.
REQ-019 alarm_en  out  NUM_ALARMS  per-slot enable.
REQ-020 alarm_ring  out  1  alarm sounding.
REQ-021 ring_slot  out  SW  slot that triggered ring.

Function
REQ-022 Key codes SHALL be: digits 8'h00-8'h09, ALARM 8'h2A, TIME 8'h2D, NEXT 8'h2B, TOGGLE 8'h2F, SHOW 8'h2E (held in keycodes.vh); other codes ignored.
REQ-023 All outputs SHALL be registered; pulse/state response appears the cycle after key_valid sampled high.
REQ-024 FSM states SHALL be IDLE, ENTRY, SHOW.
REQ-025 IDLE: digit -> shift pulse, go ENTRY; NEXT -> slot+1, wrap NUM_ALARMS-1 -> 0; TOGGLE -> alarm_en[slot] inverted; SHOW -> go SHOW; ALARM/TIME ignored.
REQ-026 ENTRY: digit -> shift pulse (unbounded; oldest digit dropped externally); ALARM -> load_alarm pulse, slot register <= key_buffer, alarm_en[slot] <= 1, go IDLE; TIME -> load_new_time pulse, go IDLE; NEXT/TOGGLE/SHOW ignored.
REQ-027 SHOW: show_alarm=1; NEXT advances slot with wrap; SHOW -> IDLE; digits/ALARM/TIME ignored.
REQ-028 ENTRY and SHOW SHALL return to IDLE with no load pulse after TIMEOUT_S one_second pulses without key_valid; each key_valid clears the timeout count.
REQ-029 alarm_time SHALL always reflect the selected slot's register.
REQ-030 Per slot an armed flag: on one_second, enabled armed slot with cur_time == register triggers; armed clears on trigger, re-sets when cur_time != register.
REQ-031 On trigger while alarm_ring=0: alarm_ring=1, ring_slot=lowest-index matching slot; matches while ringing are dropped (their armed flags still clear).
REQ-032 Ringing SHALL stop on any key_valid (that key consumed, no other effect) or after RING_S one_second pulses.
REQ-033 key_valid and one_second in same cycle: key processed, timeout count cleared, match check still performed.
REQ-034 Disabling a ringing slot via TOGGLE is impossible (key silences first); disabling a non-ringing slot takes effect immediately.

Reset
REQ-035 reset low SHALL force: state IDLE, all outputs 0, slot 0, slot registers 0, alarm_en 0, armed flags 1, counters 0.
REQ-036 reset asserted mid-ENTRY or mid-ring SHALL abort with no load pulse.

Verification
REQ-037 Digits 1,2,3,0 then ALARM -> four shift pulses, one load_alarm, slot0 reg = key_buffer, alarm_en=4'b0001.
REQ-038 Digit 5 then TIME -> one shift, one load_new_time; TIME alone in IDLE -> no pulse.
REQ-039 NEXT x4 with NUM_ALARMS=4 -> slot 1,2,3,0; SHOW -> show_alarm=1, 10 one_second pulses idle -> show_alarm=0.
REQ-040 Slots 1 and 2 both 0700 enabled, cur_time=0700 + one_second -> alarm_ring=1, ring_slot=1; any key -> alarm_ring=0, no re-ring until cur_time changes and returns.
REQ-041 Ring unanswered 60 one_second pulses -> alarm_ring=0; reset low mid-ENTRY -> outputs 0, state IDLE.
